// File: rtl/ccu_shift_sequencer.sv
// Control sequencer for the L (left shift) and R (right shift) orders.
// Decodes the shift count from {address, long_bit}, holds the Accumulator
// shifting gate g5 for one minor cycle per position, issues ds on right
// shifts, and closes the order with reset_shift_ff / done.
//
// Ports:
//   clk            digit clock, one cycle per digit period
//   rst            synchronous active-high reset
//   start          one-cycle order start pulse (accepted only in IDLE)
//   dir_right      sampled with start: 1 = R order, 0 = L order
//   shift_field    sampled with start: {address[9:0], long_bit}
//   d0, d35        first / last digit pulses of each minor cycle
//   g5             Accumulator shifting gate (to Accumulator and ccu_8)
//   ds             sign-propagation request, right shifts only
//   reset_shift_ff one-cycle pulse clearing the ccu_8 sign flip-flop
//   done           one-cycle end-of-order pulse
//   busy           high whenever an order is in progress
//   shifts_left    remaining shift count
module ccu_shift_sequencer #(
    parameter int FIELD_BITS = 11,
    parameter int CNT_BITS   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  dir_right,
    input  logic [FIELD_BITS-1:0] shift_field,
    input  logic                  d0,
    input  logic                  d35,
    output logic                  g5,
    output logic                  ds,
    output logic                  reset_shift_ff,
    output logic                  done,
    output logic                  busy,
    output logic [CNT_BITS-1:0]   shifts_left
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARM,
        S_SHIFT,
        S_FINISH
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic                r_dir;
    logic                w_dir_next;
    logic [CNT_BITS-1:0] r_cnt;
    logic [CNT_BITS-1:0] w_cnt_next;
    logic [CNT_BITS-1:0] w_count;

    // Count = 1 + position of the least-significant set bit. Scanning from
    // the top down lets the lowest set bit make the final assignment.
    always_comb begin
        w_count = '0;
        for (int i = FIELD_BITS - 1; i >= 0; i--) begin
            if (shift_field[i]) begin
                w_count = CNT_BITS'(i + 1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_dir   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_dir   <= w_dir_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_dir_next   = r_dir;
        w_cnt_next   = r_cnt;
        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_dir_next = dir_right;
                    w_cnt_next = w_count;
                    if (w_count != '0) begin
                        w_state_next = S_ARM;
                    end else begin
                        w_state_next = S_FINISH;
                    end
                end
            end
            S_ARM: begin
                // A cycle with d0 and d35 together is not a real
                // minor-cycle boundary; keep waiting.
                if (d0 && !d35) begin
                    w_state_next = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (r_cnt == '0) begin
                    w_state_next = S_FINISH;
                end else if (d35) begin
                    w_cnt_next = r_cnt - 1'b1;
                    if (r_cnt == CNT_BITS'(1)) begin
                        w_state_next = S_FINISH;
                    end
                end
            end
            S_FINISH: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // g5 opens combinationally on the arming d0 so the first shifting
    // minor cycle is covered from its very first digit.
    assign g5 = (r_state == S_SHIFT)
              | ((r_state == S_ARM) & d0 & ~d35);
    assign ds             = r_dir & g5 & d0;
    assign reset_shift_ff = (r_state == S_FINISH);
    assign done           = (r_state == S_FINISH);
    assign busy           = (r_state != S_IDLE);
    assign shifts_left    = r_cnt;

endmodule

// File: tb/tb_ccu_shift_sequencer.sv
// Self-checking bench for ccu_shift_sequencer: windows of g5/ds/done/busy
// are predicted from start time, digit phase and decoded count.
module tb_ccu_shift_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        dir_right;
    logic [10:0] shift_field;
    logic        d0;
    logic        d35;
    logic        g5;
    logic        ds;
    logic        reset_shift_ff;
    logic        done;
    logic        busy;
    logic [3:0]  shifts_left;

    int checks = 0;
    int errors = 0;
    int dig    = 0;
    int cyc    = 0;
    bit force_both = 1'b0;

    ccu_shift_sequencer #(.FIELD_BITS(11), .CNT_BITS(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .dir_right      (dir_right),
        .shift_field    (shift_field),
        .d0             (d0),
        .d35            (d35),
        .g5             (g5),
        .ds             (ds),
        .reset_shift_ff (reset_shift_ff),
        .done           (done),
        .busy           (busy),
        .shifts_left    (shifts_left)
    );

    always #5 clk = ~clk;

    task automatic drive();
        d0  = force_both || (dig == 0);
        d35 = force_both || (dig == 35);
        #1;
    endtask

    task automatic adv();
        @(posedge clk);
        dig = (dig + 1) % 36;
        cyc++;
        @(negedge clk);
    endtask

    function automatic int model_n(input logic [10:0] f);
        logic [10:0] iso;
        if (f == 11'd0) return 0;
        iso = f & (~f + 11'd1);
        return $clog2(int'(iso)) + 1;
    endfunction

    task automatic run_order(input bit dir, input logic [10:0] field,
                             input int pre, input int sec,
                             input bit fin_start, input int rst_off,
                             input int frc);
        int n, ts, t0, endc, rc, last;
        bit eg5, eds, edone, ebusy;
        int esl;
        for (int i = 0; i < pre; i++) begin
            start = 1'b0;
            drive();
            checks++;
            if (busy !== 1'b0 || g5 !== 1'b0 || done !== 1'b0) begin
                errors++;
                $display("FAIL idle_pre cyc=%0d busy=%0b g5=%0b done=%0b exp 0",
                         cyc, busy, g5, done);
            end
            adv();
        end
        n    = model_n(field);
        ts   = cyc;
        t0   = ts + 36 - dig;
        endc = (n > 0) ? t0 + 36 * n : ts + 1;
        rc   = (rst_off >= 0) ? t0 + 36 + rst_off : -1;
        last = (rc >= 0) ? rc + 4 : endc + 4;
        for (int c = ts; c <= last; c++) begin
            start = (c == ts) || (sec >= 0 && c == ts + sec)
                  || (fin_start && c == endc);
            dir_right   = (c == ts) ? dir : 1'($urandom);
            shift_field = (c == ts) ? field : 11'($urandom);
            rst         = (c == rc);
            force_both  = (frc >= 0 && c == ts + frc && c < t0);
            drive();
            if (c <= ts || (rc >= 0 && c > rc)) begin
                eg5 = 0; eds = 0; edone = 0; ebusy = 0; esl = 0;
            end else begin
                ebusy = (c <= endc);
                eg5   = (n > 0) && (c >= t0) && (c < t0 + 36 * n);
                eds   = eg5 && dir && ((c - t0) % 36 == 0);
                edone = (c == endc);
                if (c > endc || n == 0) esl = 0;
                else if (c < t0) esl = n;
                else esl = n - (c - t0) / 36;
            end
            checks++;
            if (g5 !== eg5) begin
                errors++;
                $display("FAIL g5 cyc=%0d got=%0b exp=%0b", c, g5, eg5);
            end
            checks++;
            if (ds !== eds) begin
                errors++;
                $display("FAIL ds cyc=%0d got=%0b exp=%0b", c, ds, eds);
            end
            checks++;
            if (done !== edone || reset_shift_ff !== edone) begin
                errors++;
                $display("FAIL done cyc=%0d got=%0b/%0b exp=%0b",
                         c, done, reset_shift_ff, edone);
            end
            checks++;
            if (busy !== ebusy) begin
                errors++;
                $display("FAIL busy cyc=%0d got=%0b exp=%0b", c, busy, ebusy);
            end
            checks++;
            if (int'(shifts_left) !== esl) begin
                errors++;
                $display("FAIL shifts_left cyc=%0d got=%0d exp=%0d",
                         c, shifts_left, esl);
            end
            adv();
        end
        start      = 1'b0;
        rst        = 1'b0;
        force_both = 1'b0;
    endtask

    task automatic test_reset();
        rst         = 1'b1;
        start       = 1'b1;
        dir_right   = 1'b1;
        shift_field = 11'h004;
        for (int i = 0; i < 2; i++) begin
            drive();
            if (i == 1) begin
                checks++;
                if ({g5, ds, reset_shift_ff, done, busy} !== 5'b0
                    || shifts_left !== 4'd0) begin
                    errors++;
                    $display("FAIL reset_outs got=%b/%0d exp=0/0",
                             {g5, ds, reset_shift_ff, done, busy}, shifts_left);
                end
            end
            adv();
        end
        rst   = 1'b0;
        start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            drive();
            checks++;
            if ({g5, ds, reset_shift_ff, done, busy} !== 5'b0
                || shifts_left !== 4'd0) begin
                errors++;
                $display("FAIL post_reset got=%b/%0d exp=0/0",
                         {g5, ds, reset_shift_ff, done, busy}, shifts_left);
            end
            adv();
        end
    endtask

    task automatic test_l_order();
        run_order(1'b0, 11'h004, $urandom_range(0, 40), -1, 1'b0, -1, -1);
    endtask

    task automatic test_r_single();
        run_order(1'b1, 11'h001, $urandom_range(0, 40), -1, 1'b0, -1, -1);
    endtask

    task automatic test_long_ignore_start();
        run_order(1'b0, 11'h400, $urandom_range(0, 40), 100, 1'b1, -1, -1);
    endtask

    task automatic test_zero();
        run_order(1'b1, 11'h000, $urandom_range(0, 10), -1, 1'b1, -1, -1);
        run_order(1'b0, 11'h000, 0, -1, 1'b0, -1, -1);
    endtask

    task automatic test_reset_mid();
        run_order(1'b1, 11'h010, $urandom_range(0, 40), -1, 1'b0,
                  $urandom_range(0, 35), -1);
        run_order(1'b1, 11'h002, $urandom_range(0, 40), -1, 1'b0, -1, -1);
    endtask

    task automatic test_degenerate();
        int pre;
        pre = (5 - dig + 36) % 36;
        run_order(1'b1, 11'h008, pre, -1, 1'b0, -1, 3);
    endtask

    task automatic test_random();
        int pos;
        logic [10:0] f;
        for (int k = 0; k < 16; k++) begin
            pos = $urandom_range(0, 11);
            if (pos == 11) f = 11'd0;
            else f = 11'(($urandom << pos) | (32'd1 << pos));
            run_order(1'($urandom), f, $urandom_range(0, 50),
                      (k % 3 == 0) ? 40 : -1, 1'(k % 2), -1, -1);
        end
    endtask

    initial begin
        rst         = 1'b1;
        start       = 1'b0;
        dir_right   = 1'b0;
        shift_field = '0;
        d0          = 1'b0;
        d35         = 1'b0;
        @(negedge clk);
        test_reset();
        test_l_order();
        test_r_single();
        test_long_ignore_start();
        test_zero();
        test_reset_mid();
        test_degenerate();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ccu_shift_sequencer.md
Name: ccu_shift_sequencer

Overview:
- Control sequencer for the L (left shift) and R (right shift) orders.
- Decodes the shift count from the order's address field and its long/short bit.
- Holds the Accumulator shifting gate g5 for one minor cycle per shift position, and issues ds (right shifts only) to start sign propagation.
- Terminates the order with reset_shift_ff and a done pulse. It sits directly upstream of ccu_8, which consumes g5 and reset_shift_ff to form ones2.

Parameters:
- FIELD_BITS, 11, width of the shift field {address[9:0], long_bit}; bit 0 is the long/short bit.
- CNT_BITS, 4, width of the internal shift counter; must satisfy 2^CNT_BITS > FIELD_BITS.

Ports:
- clk  input  1  digit clock; one cycle per digit period.
- rst  input  1  reset; synchronous, active-high.
- start  input  1  one-cycle pulse from order decode; starts an L or R order.
- dir_right  input  1  sampled with start; 1 = R order, 0 = L order.
- shift_field  input  FIELD_BITS  sampled with start; order address field concatenated with the long bit.
- d0  input  1  first digit pulse of each minor cycle.
- d35  input  1  last digit pulse of each minor cycle.
- g5  output  1  Accumulator shifting gate (to Accumulator and ccu_8).
- ds  output  1  sign-propagation request for right shifts (to Accumulator, which returns ds_r to ccu_8).
- reset_shift_ff  output  1  one-cycle pulse that clears the ccu_8 sign flip-flop.
- done  output  1  one-cycle end pulse for the order (to main control).
- busy  output  1  high from the cycle after an accepted start until done completes.
- shifts_left  output  CNT_BITS  remaining shift count, for debug and observation.

Behaviour:
- Reset: after rst, state = IDLE; all outputs are 0; shifts_left = 0; latched direction = 0. rst has priority over every other input in the same cycle.
- Reset mid-operation: the order is abandoned with no reset_shift_ff and no done pulse.
- Count decode, performed in the start cycle: N = 1 + index of the least-significant 1 in shift_field. Examples: bit 0 set gives N = 1; 0x002 gives N = 2; 0x400 gives N = 11. An all-zero field gives N = 0.
- States:
  - IDLE: start=1 latches dir_right and N into shifts_left. Next state is ARM if N > 0, else FINISH. start is ignored in every other state.
  - ARM: waits for a minor-cycle boundary. When d0=1 the next state is SHIFT. If d0 and d35 are high together, the degenerate cycle is ignored and the block stays in ARM.
  - SHIFT: on d35=1, shifts_left decrements. If shifts_left was 1, the next state is FINISH; otherwise the block stays in SHIFT, and the following d0 begins the next shift.
  - FINISH: lasts exactly one cycle, then returns to IDLE.
- g5 (combinational from registered state and inputs) = (state == SHIFT) | (state == ARM & d0 & ~d35). This covers d0..d35 inclusive of each shifting minor cycle. Shifts occupy N consecutive minor cycles with no gap.
- ds = latched_dir_right & g5 & d0. This gives one pulse per shifting minor cycle, only on R orders.
- reset_shift_ff = done = (state == FINISH). These are the only cycles in which either is high.
- busy = (state != IDLE).
- Latency:
  - start to first g5: the next d0 at least one cycle after start. A d0 in the start cycle itself is not used.
  - Last d35 to done: exactly 1 cycle.
  - Zero-count order: done occurs 1 cycle after start, g5 never asserts.
- A start arriving in the same cycle that FINISH occupies is ignored. A new start is accepted only in IDLE.
- Arithmetic: shifts_left never wraps. Decrement happens only in SHIFT on d35 with shifts_left ≥ 1.

Test Plan:
- Reset: drive rst for 2 cycles with start=1 and d0 toggling → all outputs 0 and state IDLE throughout; busy stays 0 after rst drops until a fresh start.
- L order, shift_field=0x004 (N=3), 36-digit minor cycles → g5 high for exactly 3×36 consecutive cycles beginning at the first d0 after start; ds never high; reset_shift_ff and done high for exactly one cycle, 1 cycle after the third d35.
- R order, shift_field=0x001 (N=1) → g5 high for one minor cycle; ds high only in that minor cycle's d0 cycle; shifts_left goes 1→0 at d35; done 1 cycle later.
- shift_field=0x400 (N=11) followed by a second start pulse mid-operation → the second start is ignored; exactly 11 g5 minor cycles; shifts_left counts 11→0.
- shift_field=0x000 → done and reset_shift_ff pulse 1 cycle after start; g5 and ds stay 0; busy is high only during the FINISH cycle.
- rst asserted during the 2nd minor cycle of an N=5 R order → g5, ds and busy drop on the next edge; no done or reset_shift_ff pulse; a following start with 0x002 executes normally (N=2).
